// File: rtl/apb_reg_completer.sv
// APB completer terminating the bus in a bank of software-visible registers.
// Per-transfer wait states; an error is returned for unmapped or misaligned addresses.
// Optional byte strobes: define APB_REG_COMPLETER_STRB_EN.
module apb_reg_completer #(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          NumRegs   = 8,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                           pclk_i,
  input  logic                           preset_ni,
  input  logic [AddrWidth-1:0]           paddr_i,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [DataWidth-1:0]           pwdata_i,
`ifdef APB_REG_COMPLETER_STRB_EN
  input  logic [DataWidth/8-1:0]         pstrb_i,
`endif
  input  logic [3:0]                     wait_cycles_i,
  output logic                           pready_o,
  output logic [DataWidth-1:0]           prdata_o,
  output logic                           pslverr_o,
  output logic [NumRegs*DataWidth-1:0]   regs_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 valid_q;
  logic                 write_q;
  logic [IdxW-1:0]      idx_q;
  logic [DataWidth-1:0] regs_q [NumRegs];

  // Address decode of the current bus address.
  logic [AddrWidth-1:0] off_c;
  logic                 valid_c;
  logic [IdxW-1:0]      idx_c;

  assign off_c   = paddr_i - BaseAddr;
  assign valid_c = (paddr_i >= BaseAddr)
                && ((off_c % AddrWidth'(NumBytes)) == '0)
                && ((off_c / AddrWidth'(NumBytes)) < AddrWidth'(NumRegs));
  assign idx_c   = IdxW'(off_c / AddrWidth'(NumBytes));

  // Response source: live decode for zero-wait setups, latched decode in ACCESS.
  logic                 rsp_valid_c;
  logic                 rsp_write_c;
  logic [IdxW-1:0]      rsp_idx_c;
  logic [DataWidth-1:0] rsp_rdata_c;

  always_comb begin
    rsp_valid_c = valid_q;
    rsp_write_c = write_q;
    rsp_idx_c   = idx_q;
    if (state_q == IDLE) begin
      rsp_valid_c = valid_c;
      rsp_write_c = pwrite_i;
      rsp_idx_c   = idx_c;
    end
    rsp_rdata_c = '0;
    if (rsp_valid_c && !rsp_write_c) begin
      rsp_rdata_c = regs_q[rsp_idx_c];
    end
  end

  // Bit-level write enable derived from the byte strobes.
  logic [DataWidth-1:0] wmask_c;

  always_comb begin
    wmask_c = '1;
`ifdef APB_REG_COMPLETER_STRB_EN
    for (int unsigned b = 0; b < NumBytes; b++) begin
      wmask_c[b*8 +: 8] = {8{pstrb_i[b]}};
    end
`endif
  end

  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      pready_o  <= 1'b0;
      prdata_o  <= '0;
      pslverr_o <= 1'b0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (psel_i && !penable_i) begin
            valid_q <= valid_c;
            write_q <= pwrite_i;
            idx_q   <= idx_c;
            cnt_q   <= wait_cycles_i;
            state_q <= ACCESS;
            if (wait_cycles_i == 4'd0) begin
              pready_o  <= 1'b1;
              prdata_o  <= rsp_rdata_c;
              pslverr_o <= !valid_c;
            end
          end
        end
        ACCESS: begin
          if (!psel_i) begin
            // Aborted transfer: drop the response, nothing commits.
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_o  <= 1'b0;
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
          end else if (penable_i) begin
            if (pready_o) begin
              state_q   <= IDLE;
              pready_o  <= 1'b0;
              prdata_o  <= '0;
              pslverr_o <= 1'b0;
              if (write_q && valid_q) begin
                regs_q[idx_q] <= (regs_q[idx_q] & ~wmask_c) | (pwdata_i & wmask_c);
              end
            end else begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                pready_o  <= 1'b1;
                prdata_o  <= rsp_rdata_c;
                pslverr_o <= !valid_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_regs_o
    assign regs_o[i*DataWidth +: DataWidth] = regs_q[i];
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed and randomized bench for apb_reg_completer against a register-array model.
module tb_apb_reg_completer;

`ifdef APB_REG_COMPLETER_STRB_EN
  localparam bit StrbEn = 1'b1;
`else
  localparam bit StrbEn = 1'b0;
`endif

  logic         pclk = 1'b0;
  logic         preset_n;
  logic [31:0]  paddr;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   cur_strb;
  logic [3:0]   wait_cycles;
  logic         pready;
  logic [31:0]  prdata;
  logic         pslverr;
  logic [255:0] regs_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [8];

  always #5 pclk = ~pclk;

  apb_reg_completer dut (
    .pclk_i        (pclk),
    .preset_ni     (preset_n),
    .paddr_i       (paddr),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .pwdata_i      (pwdata),
`ifdef APB_REG_COMPLETER_STRB_EN
    .pstrb_i       (cur_strb),
`endif
    .wait_cycles_i (wait_cycles),
    .pready_o      (pready),
    .prdata_o      (prdata),
    .pslverr_o     (pslverr),
    .regs_o        (regs_o)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit model_valid(input logic [31:0] addr);
    return (addr % 4 == 0) && (addr / 4 < 8);
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  // One transfer starting just after a rising edge; leaves the bus idle after completion.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd, input int w);
    bit          v;
    int          k;
    logic [31:0] exp_rd;
    v = model_valid(addr);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    wait_cycles = 4'(w);
    @(negedge pclk);
    check("setup_pready", 256'(pready), 256'(0));
    check("regs_o", regs_o, model_flat());
    @(posedge pclk); #1;
    penable = 1'b1;
    wait_cycles = 4'($urandom);
    k = 0;
    forever begin
      @(negedge pclk);
      if (pready) break;
      k++;
      if (k > 20) begin
        check("pready_timeout", 256'(1), 256'(0));
        break;
      end
      @(posedge pclk); #1;
    end
    check("wait_states", 256'(k), 256'(w));
    check("pslverr", 256'(pslverr), 256'(!v));
    exp_rd = (!wr && v) ? model[addr/4] : 32'h0;
    check("prdata", 256'(prdata), 256'(exp_rd));
    @(posedge pclk); #1;
    if (wr && v) begin
      for (int b = 0; b < 4; b++)
        if (!StrbEn || cur_strb[b]) model[addr/4][b*8 +: 8] = wd[b*8 +: 8];
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; cur_strb = 4'hF; wait_cycles = 4'h0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", 256'(pready), 256'(0));
    check("rst_prdata", 256'(prdata), 256'(0));
    check("rst_pslverr", 256'(pslverr), 256'(0));
    check("rst_regs", regs_o, 256'(0));
    @(posedge pclk); #1;
    preset_n = 1'b1;

    // Read index 3 with zero wait states.
    xfer(32'hC, 1'b0, 32'h0, 0);

    // Write then read back register 2.
    xfer(32'h8, 1'b1, 32'hDEADBEEF, 5);
    @(negedge pclk);
    check("reg2_after_write", 256'(regs_o[95:64]), 256'(32'hDEADBEEF));
    @(posedge pclk); #1;
    xfer(32'h8, 1'b0, 32'h0, 0);

    // Out of range and misaligned writes must error and change nothing.
    xfer(32'h20, 1'b1, 32'h12345678, 1);
    xfer(32'h2, 1'b1, 32'h87654321, 0);
    @(negedge pclk);
    check("regs_after_bad_writes", regs_o, model_flat());
    @(posedge pclk); #1;

    // Abort a W=4 write by dropping psel in access cycle 2.
    psel = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hCAFEF00D;
    wait_cycles = 4'd4;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk); check("abort_c0_pready", 256'(pready), 256'(0));
    @(posedge pclk); #1;
    @(negedge pclk); check("abort_c1_pready", 256'(pready), 256'(0));
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge pclk); check("abort_c2_pready", 256'(pready), 256'(0));
    @(posedge pclk); #1;
    @(negedge pclk);
    check("abort_pready_idle", 256'(pready), 256'(0));
    check("abort_regs", regs_o, model_flat());
    @(posedge pclk); #1;
    xfer(32'h4, 1'b0, 32'h0, 2);

    // Byte strobes (full replace when the feature is absent).
    cur_strb = 4'hF;
    xfer(32'h0, 1'b1, 32'h11223344, 0);
    cur_strb = 4'b0101;
    xfer(32'h0, 1'b1, 32'hAABBCCDD, 3);
    @(negedge pclk);
    if (StrbEn) check("strb_merge", 256'(regs_o[31:0]), 256'(32'h11BB33DD));
    else        check("full_write", 256'(regs_o[31:0]), 256'(32'hAABBCCDD));
    @(posedge pclk); #1;
    cur_strb = 4'b0000;
    xfer(32'h0, 1'b1, 32'h55555555, 0);
    xfer(32'h0, 1'b0, 32'h0, 1);

    // Ten back-to-back random transfers.
    for (int n = 0; n < 10; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 9) * 4);
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      cur_strb = 4'($urandom);
      xfer(a, 1'($urandom), $urandom, int'($urandom_range(0, 15)));
    end
    @(negedge pclk);
    check("regs_final", regs_o, model_flat());
    @(posedge pclk); #1;

    // Reset in the middle of a write drops it and clears everything.
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hFFFFFFFF;
    wait_cycles = 4'd6;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; preset_n = 1'b0;
    @(posedge pclk); #1; preset_n = 1'b1; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    @(negedge pclk);
    check("midrst_pready", 256'(pready), 256'(0));
    check("midrst_regs", regs_o, model_flat());
    @(posedge pclk); #1;
    xfer(32'h1C, 1'b0, 32'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_reg_completer.md
# apb_reg_completer

APB completer (slave) terminating an APB bus in a bank of software-visible registers, with a per-transfer programmable wait-state count and error response on bad addresses. It is the responder end of the APB links driven by the apb_cdc destination side and by bus masters in the peripheral subsystem. It serves as a synthesizable stand-in for the random testbench slave, and as the register front-end for simple peripherals.

## Interface
- AddrWidth, 32: APB address width.
- DataWidth, 32: APB data width. Must be a multiple of 8, from 8 to 64.
- NumRegs, 8: number of DataWidth-bit registers. Range 1..256.
- BaseAddr, 32'h0: byte address of register 0. Must be aligned to DataWidth/8.
- pclk_i  in  1  clock; all logic is on its rising edge.
- preset_ni  in  1  synchronous active-low reset.
- paddr_i  in  AddrWidth  transfer address.
- psel_i  in  1  completer select.
- penable_i  in  1  access phase indicator.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  DataWidth  write data.
- pstrb_i  in  DataWidth/8  byte strobes. Present only with APB_REG_COMPLETER_STRB_EN.
- wait_cycles_i  in  4  wait states to insert. Sampled in the setup phase.
- pready_o  out  1  transfer completion. Registered.
- prdata_o  out  DataWidth  read data. Registered. Valid only while pready_o=1 on a read.
- pslverr_o  out  1  error response. Registered. Valid only while pready_o=1.
- regs_o  out  NumRegs*DataWidth  register contents; register i is at bits [i*DataWidth +: DataWidth].

## Operation
- Decode: off = paddr_i - BaseAddr. The address is valid iff all of the following hold: paddr_i >= BaseAddr; off is aligned to DataWidth/8; off/(DataWidth/8) < NumRegs. Index = off/(DataWidth/8).
- FSM states: IDLE and ACCESS.
- IDLE:
  - On psel_i=1 & penable_i=0 (setup phase): latch index, valid flag and direction; load cnt = wait_cycles_i; go to ACCESS.
  - If wait_cycles_i==0, also register pready_o<=1, with prdata_o and pslverr_o computed at the same time.
- ACCESS (psel_i=1 & penable_i=1):
  - If pready_o==0: decrement cnt. When cnt==1 before the decrement, register pready_o<=1 with the response.
  - If pready_o==1: the transfer completes this cycle. Register pready_o<=0, prdata_o<=0, pslverr_o<=0. A valid write commits to the register at this edge. Go to IDLE.
- Read response:
  - valid: prdata_o = register[index], pslverr_o = 0.
  - invalid: prdata_o = 0, pslverr_o = 1.
- Write response: pslverr_o = !valid. An invalid write modifies nothing.
- Abort: if psel_i drops in ACCESS before completion, go to IDLE. Clear pready_o, prdata_o and pslverr_o. No write commits.
- Back-to-back: a setup phase in the cycle after completion is accepted from IDLE with no dead cycle.
- Reads and writes never overlap, so read data is always coherent with regs_o.

## Timing
- Reset (preset_ni=0 at an edge): FSM=IDLE, cnt=0, all registers=0, pready_o=0, prdata_o=0, pslverr_o=0, regs_o=0.
- Reset mid-transfer: the transfer is dropped and no write commits. Reset has priority over everything.
- With W = wait_cycles_i sampled at setup, pready_o rises in access cycle W. Access cycles are counted from 0.
  - W=0: zero wait states, 2-cycle transfer.
  - W=15: 17-cycle transfer.
- A write is visible on regs_o one cycle after the completion cycle.
- pready_o is never high outside ACCESS and is high for exactly one cycle per transfer.
- wait_cycles_i changes during ACCESS have no effect on the current transfer.

## Configuration
- APB_REG_COMPLETER_STRB_EN defined:
  - pstrb_i exists.
  - A valid write updates only the bytes whose strobe is 1.
  - All-zero strobes give a completed write with no update and pslverr_o=0.
  - pstrb_i is ignored on reads.
- Undefined: pstrb_i is absent and every valid write replaces the whole register.

## Test plan
- Reset, then read index 3 with W=0: pready_o high in access cycle 0, prdata_o=0, pslverr_o=0; all outputs were 0 during reset.
- Write 32'hDEADBEEF to BaseAddr+8 with W=5, then read it back with W=0: the write's pready_o rises in access cycle 5, regs_o[95:64]=32'hDEADBEEF on the next cycle, and the read returns 32'hDEADBEEF.
- Write to BaseAddr+NumRegs*4, then write to BaseAddr+2 (misaligned): pslverr_o=1 with pready_o on each, regs_o unchanged.
- Start a write with W=4 and drop psel_i in access cycle 2: FSM returns to IDLE, pready_o stays 0, no register changes. A following read completes normally.
- Ten back-to-back transfers with random W in 0..15 against a reference model: every completion occurs at exactly W wait states and the data matches the model.
- STRB_EN build: register 0 preset to 32'h11223344, write 32'hAABBCCDD with pstrb_i=4'b0101 → register 0 = 32'h11BB33DD.
